// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit owning HI/LO; fixed-latency mult/div plus mthi/mtlo/mfhi/mflo.
// Optional MDU_DIV_ZERO_FAST_EN: divide by zero completes with no busy cycles.
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        req,
    output logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] md_out
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMthi  = 4'd5;
    localparam logic [3:0] OpMtlo  = 4'd6;
    localparam logic [3:0] OpMfhi  = 4'd7;
    localparam logic [3:0] OpMflo  = 4'd8;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     counter_q, counter_d;
    logic [31:0]         temp_hi_q, temp_hi_d;
    logic [31:0]         temp_lo_q, temp_lo_d;
    logic [31:0]         hi_q, hi_d;
    logic [31:0]         lo_q, lo_d;
    logic                busy_q, busy_d;

    logic                is_mul, is_div, div_zero;
    logic [63:0]         prod_s, prod_u;
    logic [31:0]         divisor;
    logic [31:0]         quot_s, rem_s, quot_u, rem_u;

    assign is_mul   = (md_op == OpMult) || (md_op == OpMultu);
    assign is_div   = (md_op == OpDiv) || (md_op == OpDivu);
    assign div_zero = is_div && (E_B == 32'd0);

    assign prod_s = {{32{E_A[31]}}, E_A} * {{32{E_B[31]}}, E_B};
    assign prod_u = {32'd0, E_A} * {32'd0, E_B};

    // Substitute a nonzero divisor so the dividers never see zero; that result is discarded.
    assign divisor = (E_B == 32'd0) ? 32'd1 : E_B;
    assign quot_s  = $signed(E_A) / $signed(divisor);
    assign rem_s   = $signed(E_A) % $signed(divisor);
    assign quot_u  = E_A / divisor;
    assign rem_u   = E_A % divisor;

    assign start  = (is_mul || is_div) && !busy_q && !req;
    assign busy   = busy_q;
    assign HI     = hi_q;
    assign LO     = lo_q;

    always_comb begin
        md_out = 32'd0;
        if (md_op == OpMfhi) begin
            md_out = hi_q;
        end else if (md_op == OpMflo) begin
            md_out = lo_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        temp_hi_d = temp_hi_q;
        temp_lo_d = temp_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
`ifdef MDU_DIV_ZERO_FAST_EN
                    if (!div_zero) begin
                        state_d   = StRun;
                        busy_d    = 1'b1;
                        counter_d = is_mul ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
                    end
`else
                    state_d   = StRun;
                    busy_d    = 1'b1;
                    counter_d = is_mul ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
`endif
                    unique case (md_op)
                        OpMult:  {temp_hi_d, temp_lo_d} = prod_s;
                        OpMultu: {temp_hi_d, temp_lo_d} = prod_u;
                        OpDiv: begin
                            temp_hi_d = rem_s;
                            temp_lo_d = quot_s;
                        end
                        default: begin
                            temp_hi_d = rem_u;
                            temp_lo_d = quot_u;
                        end
                    endcase
                    // Divide by zero commits the current HI/LO, leaving them unchanged.
                    if (div_zero) begin
                        temp_hi_d = hi_q;
                        temp_lo_d = lo_q;
                    end
                end else if (!req && (md_op == OpMthi)) begin
                    hi_d = E_A;
                end else if (!req && (md_op == OpMtlo)) begin
                    lo_d = E_A;
                end
            end
            StRun: begin
                counter_d = counter_q - CntW'(1);
                if (counter_q == CntW'(1)) begin
                    hi_d    = temp_hi_q;
                    lo_d    = temp_lo_q;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            counter_q <= '0;
            temp_hi_q <= 32'd0;
            temp_lo_q <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            temp_hi_q <= temp_hi_d;
            temp_lo_q <= temp_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit; default parameters (5 mult, 10 div cycles).
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  md_op;
    logic [31:0] E_A, E_B;
    logic        req;
    logic        start, busy;
    logic [31:0] HI, LO, md_out;

    int n_checks = 0;
    int n_fail   = 0;

    mult_div_unit dut (
        .clk    (clk),
        .reset  (reset),
        .md_op  (md_op),
        .E_A    (E_A),
        .E_B    (E_B),
        .req    (req),
        .start  (start),
        .busy   (busy),
        .HI     (HI),
        .LO     (LO),
        .md_out (md_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        md_op = op;
        E_A   = a;
        E_B   = b;
        #1;
    endtask

    // Expects busy high for n cycles starting right after the issuing edge.
    task automatic expect_busy(input string tag, input int n);
        int bad = 0;
        for (int i = 1; i <= n; i++) begin
            if (busy !== 1'b1) bad++;
            tick();
        end
        check_eq(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        md_op = 4'd0;
        E_A   = 32'd0;
        E_B   = 32'd0;
        req   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_eq("reset_hi", HI, 32'd0);
        check_eq("reset_lo", LO, 32'd0);
        check_eq("reset_busy", {31'd0, busy}, 32'd0);
        check_eq("idle_md_out", md_out, 32'd0);

        // mult -2 * 3
        issue(4'd1, 32'hFFFF_FFFE, 32'd3);
        check_eq("mult_start", {31'd0, start}, 32'd1);
        tick();
        issue(4'd0, 32'd0, 32'd0);
        expect_busy("mult_busy_window", 5);
        check_eq("mult_busy_clear", {31'd0, busy}, 32'd0);
        check_eq("mult_hi", HI, 32'hFFFF_FFFF);
        check_eq("mult_lo", LO, 32'hFFFF_FFFA);

        // multu back-to-back, then mflo/mfhi
        issue(4'd2, 32'hFFFF_FFFF, 32'd2);
        check_eq("multu_start_b2b", {31'd0, start}, 32'd1);
        tick();
        issue(4'd0, 32'd0, 32'd0);
        check_eq("busy_start_blocked", {31'd0, start}, 32'd0);
        issue(4'd7, 32'd0, 32'd0);
        check_eq("mfhi_while_busy_old", md_out, 32'hFFFF_FFFF);
        issue(4'd0, 32'd0, 32'd0);
        expect_busy("multu_busy_window", 5);
        issue(4'd8, 32'd0, 32'd0);
        check_eq("mflo_out", md_out, 32'hFFFF_FFFE);
        issue(4'd7, 32'd0, 32'd0);
        check_eq("mfhi_out", md_out, 32'h0000_0001);
        issue(4'd9, 32'd0, 32'd0);
        check_eq("bad_op_md_out", md_out, 32'd0);
        check_eq("bad_op_start", {31'd0, start}, 32'd0);

        // div -7 / 2, then divu 7 / 2 back-to-back
        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        tick();
        issue(4'd0, 32'd0, 32'd0);
        expect_busy("div_busy_window", 10);
        check_eq("div_lo", LO, 32'hFFFF_FFFD);
        check_eq("div_hi", HI, 32'hFFFF_FFFF);
        issue(4'd4, 32'd7, 32'd2);
        check_eq("divu_start_b2b", {31'd0, start}, 32'd1);
        tick();
        issue(4'd0, 32'd0, 32'd0);
        expect_busy("divu_busy_window", 10);
        check_eq("divu_lo", LO, 32'd3);
        check_eq("divu_hi", HI, 32'd1);

        // req suppression
        req = 1'b1;
        issue(4'd5, 32'h1234_5678, 32'd0);
        tick();
        check_eq("mthi_req_hi", HI, 32'd1);
        req = 1'b0;
        #1;
        tick();
        check_eq("mthi_hi", HI, 32'h1234_5678);
        req = 1'b1;
        issue(4'd1, 32'd3, 32'd4);
        check_eq("mult_req_start", {31'd0, start}, 32'd0);
        tick();
        check_eq("mult_req_busy", {31'd0, busy}, 32'd0);
        check_eq("mult_req_lo", LO, 32'd3);
        req = 1'b0;

        // div 100/7 with req pulse mid-flight
        issue(4'd3, 32'd100, 32'd7);
        tick();
        issue(4'd0, 32'd0, 32'd0);
        for (int i = 1; i <= 10; i++) begin
            req = (i == 3);
            #1;
            tick();
        end
        req = 1'b0;
        check_eq("div_req_busy", {31'd0, busy}, 32'd0);
        check_eq("div_req_lo", LO, 32'd14);
        check_eq("div_req_hi", HI, 32'd2);

        // reset mid-divide
        issue(4'd3, 32'd9, 32'd3);
        tick();
        issue(4'd0, 32'd0, 32'd0);
        tick();
        tick();
        tick();
        check_eq("div_busy_c4", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_hi", HI, 32'd0);
        check_eq("abort_lo", LO, 32'd0);

        // divide by zero
        issue(4'd5, 32'hA, 32'd0);
        tick();
        issue(4'd6, 32'hB, 32'd0);
        tick();
        issue(4'd4, 32'd5, 32'd0);
        check_eq("divz_start", {31'd0, start}, 32'd1);
        tick();
        issue(4'd0, 32'd0, 32'd0);
`ifdef MDU_DIV_ZERO_FAST_EN
        check_eq("divz_fast_busy", {31'd0, busy}, 32'd0);
        tick();
        check_eq("divz_fast_busy2", {31'd0, busy}, 32'd0);
`else
        expect_busy("divz_busy_window", 10);
        check_eq("divz_busy_clear", {31'd0, busy}, 32'd0);
`endif
        check_eq("divz_hi", HI, 32'hA);
        check_eq("divz_lo", LO, 32'hB);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
